// File: rtl/gpio_pkg.sv
// Shared register offsets, edge-mode encoding and address decode for the MMIO GPIO block.
package gpio_pkg;

  localparam logic [4:0] OFF_OUT  = 5'h00;
  localparam logic [4:0] OFF_SET  = 5'h04;
  localparam logic [4:0] OFF_CLR  = 5'h08;
  localparam logic [4:0] OFF_DIR  = 5'h0C;
  localparam logic [4:0] OFF_IN   = 5'h10;
  localparam logic [4:0] OFF_EN   = 5'h14;
  localparam logic [4:0] OFF_STAT = 5'h18;
  localparam logic [4:0] OFF_MODE = 5'h1C;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_mode_e;

  // Word-aligned access inside the 32-byte window starting at base.
  function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:5] == base[31:5]) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Reset-clearable multi-stage flop chain used to bring asynchronous pins into the clock domain.
module gpio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: output/direction registers with atomic set/clear, synchronised inputs
// and per-pin edge interrupts, overlaid on the data-memory read path.
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 32,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_mem,
  input  logic                read_mem,
  input  logic [31:0]         data_address,
  input  logic [31:0]         data_to_write,
  input  logic [31:0]         data_from_mem,
  output logic [31:0]         data_read,
  output logic [NUM_PINS-1:0] IO_out,
  output logic [NUM_PINS-1:0] IO_oe,
  input  logic [NUM_PINS-1:0] IO_in,
  output logic                irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d, mode_q, mode_d;
  logic [NUM_PINS-1:0] stat_q, stat_d, stat_clr;
  logic [NUM_PINS-1:0] in_sync, in_prev_q, evt, wdata;
  logic [2:0]          prime_q, prime_d;
  logic                hit, primed;
  logic [4:0]          off;
  logic [31:0]         reg_rdata;

  gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (IO_in),
    .q   (in_sync)
  );

  assign hit    = reg_hit(data_address, BASE_ADDR);
  assign off    = data_address[4:0];
  assign wdata  = data_to_write[NUM_PINS-1:0];
  // Edges are ignored until the chain and in_prev hold real pin values after reset.
  assign primed = (prime_q == PRIME_MAX);
  assign prime_d = primed ? prime_q : prime_q + 3'd1;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      if (edge_mode_e'(mode_q[i]) == EDGE_FALL) evt[i] = primed & ~in_sync[i] & in_prev_q[i];
      else                                      evt[i] = primed & in_sync[i] & ~in_prev_q[i];
    end
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    en_d     = en_q;
    mode_d   = mode_q;
    stat_clr = '0;
    if (write_mem && hit) begin
      case (off)
        OFF_OUT:  out_d    = wdata;
        OFF_SET:  out_d    = out_q | wdata;
        OFF_CLR:  out_d    = out_q & ~wdata;
        OFF_DIR:  dir_d    = wdata;
        OFF_EN:   en_d     = wdata;
        OFF_STAT: stat_clr = wdata;
        OFF_MODE: mode_d   = wdata;
        default:  ;
      endcase
    end
    // A new event beats a simultaneous clear so it is never lost.
    stat_d = (stat_q & ~stat_clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      stat_q    <= '0;
      in_prev_q <= '0;
      prime_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      stat_q    <= stat_d;
      in_prev_q <= in_sync;
      prime_q   <= prime_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (off)
      OFF_OUT, OFF_SET, OFF_CLR: reg_rdata[NUM_PINS-1:0] = out_q;
      OFF_DIR:                   reg_rdata[NUM_PINS-1:0] = dir_q;
      OFF_IN:                    reg_rdata[NUM_PINS-1:0] = in_sync;
      OFF_EN:                    reg_rdata[NUM_PINS-1:0] = en_q;
      OFF_STAT:                  reg_rdata[NUM_PINS-1:0] = stat_q;
      OFF_MODE:                  reg_rdata[NUM_PINS-1:0] = mode_q;
      default:                   reg_rdata = '0;
    endcase
    data_read = (read_mem && hit) ? reg_rdata : data_from_mem;
  end

  assign IO_out = out_q;
  assign IO_oe  = dir_q;
  assign irq    = |(stat_q & en_q);

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio: a 32-pin and an 8-pin instance share one bus.
module tb_mmio_gpio;
  import gpio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFE0;
  localparam logic [31:0] MEMD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_mem = 1'b0;
  logic        read_mem = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_to_write = '0;
  logic [31:0] data_from_mem = MEMD;
  logic [31:0] rd32, rd8;
  logic [31:0] out32, oe32, io_in32;
  logic [7:0]  out8, oe8, io_in8;
  logic        irq32, irq8;
  logic [31:0] r32, r8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_gpio #(
    .NUM_PINS    (32),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (2)
  ) dut32 (
    .clk           (clk),
    .rst           (rst),
    .write_mem     (write_mem),
    .read_mem      (read_mem),
    .data_address  (data_address),
    .data_to_write (data_to_write),
    .data_from_mem (data_from_mem),
    .data_read     (rd32),
    .IO_out        (out32),
    .IO_oe         (oe32),
    .IO_in         (io_in32),
    .irq           (irq32)
  );

  mmio_gpio #(
    .NUM_PINS    (8),
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk           (clk),
    .rst           (rst),
    .write_mem     (write_mem),
    .read_mem      (read_mem),
    .data_address  (data_address),
    .data_to_write (data_to_write),
    .data_from_mem (data_from_mem),
    .data_read     (rd8),
    .IO_out        (out8),
    .IO_oe         (oe8),
    .IO_in         (io_in8),
    .irq           (irq8)
  );

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_address  = a;
    data_to_write = d;
    write_mem     = 1'b1;
    step();
    write_mem     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v32, output logic [31:0] v8);
    data_address = a;
    read_mem     = 1'b1;
    #1;
    v32 = rd32;
    v8  = rd8;
    read_mem = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, BASE + 32'h00, 32'h0000_00F0, BASE + 32'h00, 32'h0000_00F0, 32'hF0, 32'h00};
    vecs[1]  = '{1'b1, BASE + 32'h04, 32'h0000_000F, BASE + 32'h04, 32'h0000_00FF, 32'hFF, 32'h00};
    vecs[2]  = '{1'b1, BASE + 32'h08, 32'h0000_0030, BASE + 32'h08, 32'h0000_00CF, 32'hCF, 32'h00};
    vecs[3]  = '{1'b0, BASE + 32'h00, 32'h0000_0000, BASE + 32'h00, 32'h0000_00CF, 32'hCF, 32'h00};
    vecs[4]  = '{1'b1, BASE + 32'h0C, 32'h0000_00A5, BASE + 32'h0C, 32'h0000_00A5, 32'hCF, 32'hA5};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000, MEMD,          32'hCF, 32'hA5};
    vecs[6]  = '{1'b0, BASE + 32'h01, 32'h0000_0000, BASE + 32'h01, MEMD,          32'hCF, 32'hA5};
    vecs[7]  = '{1'b1, BASE + 32'h02, 32'h0000_0000, BASE + 32'h02, MEMD,          32'hCF, 32'hA5};
    vecs[8]  = '{1'b1, BASE + 32'h10, 32'h0000_1234, BASE + 32'h10, 32'h0000_0000, 32'hCF, 32'hA5};
    vecs[9]  = '{1'b0, 32'hFFFF_FFDC, 32'h0000_0000, 32'hFFFF_FFDC, MEMD,          32'hCF, 32'hA5};
    vecs[10] = '{1'b1, 32'h0000_1000, 32'h0000_0000, BASE + 32'h00, 32'h0000_00CF, 32'hCF, 32'hA5};

    // Pins held high through reset must not raise interrupts once released.
    io_in32 = 32'hFFFF_FFFF;
    io_in8  = 8'hFF;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset IO_out", out32, 32'h0);
    check("reset IO_oe", oe32, 32'h0);
    check("reset irq", {31'h0, irq32}, 32'h0);
    check("reset IO_out8", {24'h0, out8}, 32'h0);
    check("reset irq8", {31'h0, irq8}, 32'h0);

    wr(BASE + 32'(OFF_EN), 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("prime irq c%0d", i), {30'h0, irq32, irq8}, 32'h0);
    end
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("prime stat32", r32, 32'h0);
    check("prime stat8", r8, 32'h0);
    rd(BASE + 32'(OFF_IN), r32, r8);
    check("in all high 32", r32, 32'hFFFF_FFFF);
    check("in all high 8", r8, 32'h0000_00FF);

    // Falling pins in rise mode leave status untouched.
    io_in32 = 32'h0;
    repeat (4) step();
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("fall in rise mode", r32, 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, r32, r8);
      check($sformatf("tbl%0d read", i), r32, vecs[i].exp_rd);
      check($sformatf("tbl%0d IO_out", i), out32, vecs[i].exp_out);
      check($sformatf("tbl%0d IO_oe", i), oe32, vecs[i].exp_oe);
    end

    data_address = BASE;
    read_mem = 1'b0;
    #1;
    check("no read_mem passthrough", rd32, MEMD);

    // Rise on pin 0: IN after edge k+1, status and irq after edge k+2.
    wr(BASE + 32'(OFF_EN), 32'h1);
    io_in32[0] = 1'b1;
    step();
    rd(BASE + 32'(OFF_IN), r32, r8);
    check("in edge k", r32, 32'h0);
    step();
    rd(BASE + 32'(OFF_IN), r32, r8);
    check("in edge k+1", r32, 32'h1);
    check("irq edge k+1", {31'h0, irq32}, 32'h0);
    step();
    check("irq edge k+2", {31'h0, irq32}, 32'h1);
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("stat edge k+2", r32, 32'h1);

    // Clear lands on the same edge as a new rise: status must survive.
    io_in32[0] = 1'b0;
    repeat (4) step();
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("stat held", r32, 32'h1);
    io_in32[0] = 1'b1;
    step();
    step();
    wr(BASE + 32'(OFF_STAT), 32'h1);
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("set beats clear", r32, 32'h1);
    check("irq after race", {31'h0, irq32}, 32'h1);
    wr(BASE + 32'(OFF_STAT), 32'h1);
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("w1c clears", r32, 32'h0);
    check("irq after w1c", {31'h0, irq32}, 32'h0);

    // Fall mode on pin 0.
    wr(BASE + 32'(OFF_MODE), 32'h1);
    io_in32[0] = 1'b0;
    repeat (3) step();
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("fall mode stat", r32, 32'h1);
    wr(BASE + 32'(OFF_STAT), 32'h1);

    // Narrow instance: upper bits read 0, pin 3 falling edge.
    wr(BASE + 32'(OFF_OUT), 32'hFFFF_FFFF);
    rd(BASE + 32'(OFF_OUT), r32, r8);
    check("out8 readback", r8, 32'h0000_00FF);
    check("out32 readback", r32, 32'hFFFF_FFFF);
    check("IO_out8", {24'h0, out8}, 32'h0000_00FF);
    wr(BASE + 32'(OFF_MODE), 32'h8);
    io_in8 = 8'hF7;
    repeat (3) step();
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("stat8 pin3 fall", r8, 32'h0000_0008);
    check("stat32 quiet", r32, 32'h0);
    check("irq8 masked", {31'h0, irq8}, 32'h0);

    // Reset mid-operation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst IO_out", out32, 32'h0);
    check("midrst IO_oe", oe32, 32'h0);
    check("midrst IO_out8", {24'h0, out8}, 32'h0);
    rd(BASE + 32'(OFF_STAT), r32, r8);
    check("midrst stat8", r8, 32'h0);
    rd(BASE + 32'(OFF_MODE), r32, r8);
    check("midrst mode32", r32, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
